// File: rtl/mem_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the data-memory access arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//                               (16 x 32-bit data memory).
//   - state_t                 : arbiter sequencing states.
//   - mem_req_t               : one latched memory request (write, addr, wdata).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_PORTS  = 2;

  // IDLE waits for a request; ACCESS and RESP each last exactly one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request fields captured on the accept edge. The struct is sized by the
  // package defaults, so any top-level width override must be mirrored here.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter_if
//   Bundles the two requester handshakes and the memory bus of the arbiter.
//   Requester N (N = 0 CPU load/store stage, N = 1 debug/DMA loader):
//     reqN_valid/write/addr/wdata  request from the requester
//     reqN_ready                   request accepted this cycle
//     rspN_valid/rdata             one-cycle completion pulse and load data
//   Memory side:
//     mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en  to memory
//     mem_rdata                                                       from memory
//   Status:
//     busy                         arbiter is not in IDLE
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_access_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Port 0
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  // Port 1
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  // Memory bus
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ldr_str_en;
  logic              mem_load_en;
  logic              mem_store_en;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
    input  mem_rdata,
    output busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_wdata, mem_ldr_str_en, mem_load_en, mem_store_en,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-input round-robin grant.
//   Ports:
//     clk, rst  clock and asynchronous active-high reset
//     req[1:0]  request vector
//     advance   the current grant was taken; rotate priority away from it
//     grant[1:0] one-hot grant (all zero when nothing is requested)
//   A lone request is granted directly. On contention the port holding
//   priority wins. Priority resets to port 0 and, after every taken grant,
//   moves to the port that was not granted.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the port that wins the next contention.
  logic prio_reg;
  logic prio_next;

  always_comb begin
    grant = req;
    if (&req) begin
      grant           = 2'b00;
      grant[prio_reg] = 1'b1;
    end
  end

  // Granted port 1 -> priority 0, granted port 0 -> priority 1.
  always_comb begin
    prio_next = prio_reg;
    if (advance && (|grant)) begin
      prio_next = ~grant[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//   Shares a single-port 16 x 32-bit data memory between the CPU load/store
//   stage (port 0) and the debug/DMA loader (port 1).
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  mem_access_arbiter_if.slave: both request/response handshakes,
//          the memory bus and the busy flag
//   Sequence per transaction: IDLE (accept) -> ACCESS (one-cycle memory
//   strobe) -> RESP (one-cycle rsp_valid to the requesting port) -> IDLE.
//   At most one access per three cycles, so the memory never sees two
//   accesses in the same cycle.
// -----------------------------------------------------------------------------
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_arbiter_if.slave   bus
);

  state_t            state_reg;
  state_t            state_next;

  mem_req_t          req_reg;     // request being served
  logic              port_reg;    // port that owns req_reg

  logic [1:0]        req_valid;
  mem_req_t          req_view [NUM_PORTS];
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic [1:0]        rsp_valid;
  logic              accept;
  logic              capture;

  logic              ldr_str_en;
  logic              load_en;
  logic              store_en;

  // ---------------------------------------------------------------------------
  // Request gathering and arbitration
  // ---------------------------------------------------------------------------
  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_view[0] = {bus.req0_write, bus.req0_addr, bus.req0_wdata};
  assign req_view[1] = {bus.req1_write, bus.req1_addr, bus.req1_wdata};

  // The arbiter only sees requests while IDLE, so a request raised during
  // ACCESS/RESP neither gets ready nor moves the round-robin pointer.
  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst     (rst),
    .req     ((state_reg == IDLE) ? req_valid : 2'b00),
    .advance (accept),
    .grant   (grant)
  );

  assign accept  = (state_reg == IDLE) && (|grant);
  assign capture = (state_reg == ACCESS);

  // ---------------------------------------------------------------------------
  // Sequencer: next state and memory strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ldr_str_en = 1'b0;
    load_en    = 1'b0;
    store_en   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ldr_str_en = 1'b1;
        load_en    = ~req_reg.write;
        store_en   = req_reg.write;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes and status decode straight from the asynchronously reset state
  // register, so they drop the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      port_reg  <= 1'b0;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        port_reg <= grant[1];
        req_reg  <= req_view[grant[1]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port handshake and response data
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      // Holds the last response for this port; stores return zero.
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (capture && (port_reg == 1'(gi))) begin
          rdata_reg <= req_reg.write ? '0 : bus.mem_rdata;
        end
      end

      assign ready[gi]     = grant[gi];
      assign rsp_valid[gi] = (state_reg == RESP) && (port_reg == 1'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req0_ready     = ready[0];
  assign bus.req1_ready     = ready[1];
  assign bus.rsp0_valid     = rsp_valid[0];
  assign bus.rsp1_valid     = rsp_valid[1];
  assign bus.rsp0_rdata     = g_port[0].rdata_reg;
  assign bus.rsp1_rdata     = g_port[1].rdata_reg;

  // Address and write data come from the latched request, so they keep
  // their last values between accesses.
  assign bus.mem_addr       = req_reg.addr;
  assign bus.mem_wdata      = req_reg.wdata;
  assign bus.mem_ldr_str_en = ldr_str_en;
  assign bus.mem_load_en    = load_en;
  assign bus.mem_store_en   = store_en;

  assign bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          port;
    mem_req_t    req;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_arbiter_if bus ();

  mem_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [31:0] mem_array [16] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                                  32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12,
                                  32'd13, 32'd14, 32'd15, 32'd16};
  assign bus.mem_rdata = mem_array[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_store_en) mem_array[bus.mem_addr] <= bus.mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] ref_mem [16];
  mem_req_t    pq [2][$];
  bit          pres [2];
  int          last_grant = 1;   // port 0 wins the first contention
  int          m_wait = 0;       // cycles until the model is back in IDLE
  bit          dense = 1'b1;
  logic [31:0] held [2];
  exp_t        acc_q [$];
  exp_t        rsp_q [$];
  bit          mon_en = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic mem_req_t rand_txn();
    mem_req_t t;
    t.write = 1'($urandom_range(0, 1));
    t.addr  = 4'($urandom_range(0, 15));
    t.wdata = $urandom;
    return t;
  endfunction

  function automatic mem_req_t mk(logic w, int a, logic [31:0] d);
    mem_req_t t;
    t.write = w;
    t.addr  = 4'(a);
    t.wdata = d;
    return t;
  endfunction

  task automatic drive(int p, logic v, mem_req_t t);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = t.write;
      bus.req0_addr  = t.addr; bus.req0_wdata = t.wdata;
    end else begin
      bus.req1_valid = v; bus.req1_write = t.write;
      bus.req1_addr  = t.addr; bus.req1_wdata = t.wdata;
    end
  endtask

  // One clock cycle of stimulus plus the reference model's accept decision.
  task automatic step();
    int          win;
    int          cur;
    mem_req_t    t;
    logic [31:0] rd;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!pres[p] && pq[p].size() > 0 && (dense || $urandom_range(0, 2) != 0))
        pres[p] = 1'b1;
      if (pres[p]) drive(p, 1'b1, pq[p][0]);
      else         drive(p, 1'b0, rand_txn());
    end
    #1;
    win = -1;
    if (m_wait == 0) begin
      if (pres[0] && pres[1]) win = (last_grant == 0) ? 1 : 0;
      else if (pres[0])       win = 0;
      else if (pres[1])       win = 1;
    end
    check("req0_ready", 64'(bus.req0_ready), 64'(win == 0));
    check("req1_ready", 64'(bus.req1_ready), 64'(win == 1));
    check("busy", 64'(bus.busy), 64'(m_wait != 0));
    cur = cyc;
    @(posedge clk);
    if (win >= 0) begin
      t = pq[win].pop_front();
      pres[win] = 1'b0;
      rd = t.write ? 32'd0 : ref_mem[t.addr];
      if (t.write) ref_mem[t.addr] = t.wdata;
      acc_q.push_back('{win, t, rd, cur + 1});
      rsp_q.push_back('{win, t, rd, cur + 2});
      last_grant = win;
      m_wait = 2;
      n_txn++;
      $display("txn %0d: port %0d %s addr %0d wdata 0x%08h expect rdata 0x%08h accept cycle %0d",
               n_txn, win, t.write ? "store" : "load ", t.addr, t.wdata, rd, cur);
    end else if (m_wait > 0) begin
      m_wait--;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || m_wait != 0 || rsp_q.size() > 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'd1, 64'd0);
    step();
    step();
  endtask

  // Monitor: compares memory strobes and responses against the scoreboard.
  exp_t        mon_e;
  logic [1:0]  rsp_vec;
  logic [31:0] rsp_rd [2];
  always @(negedge clk) begin
    #1;
    if (!rst && mon_en) begin
      while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        check("mem_strobe_missing", 64'd0, 64'd1);
        void'(acc_q.pop_front());
      end
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        check("rsp_missing", 64'd0, 64'd1);
        void'(rsp_q.pop_front());
      end
      if (bus.mem_load_en || bus.mem_store_en || bus.mem_ldr_str_en) begin
        if (acc_q.size() == 0) begin
          check("mem_strobe_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = acc_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("mem_addr", 64'(bus.mem_addr), 64'(mon_e.req.addr));
          check("mem_ldr_str_en", 64'(bus.mem_ldr_str_en), 64'd1);
          check("mem_load_en", 64'(bus.mem_load_en), 64'(!mon_e.req.write));
          check("mem_store_en", 64'(bus.mem_store_en), 64'(mon_e.req.write));
          if (mon_e.req.write) check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_e.req.wdata));
        end
      end
      rsp_vec   = {bus.rsp1_valid, bus.rsp0_valid};
      rsp_rd[0] = bus.rsp0_rdata;
      rsp_rd[1] = bus.rsp1_rdata;
      if (rsp_vec != 2'b00) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_vec), 64'd0);
        end else begin
          mon_e = rsp_q.pop_front();
          check("rsp_valid_port", 64'(rsp_vec), (mon_e.port == 0) ? 64'd1 : 64'd2);
          check("rsp_rdata", 64'(rsp_rd[mon_e.port]), 64'(mon_e.rdata));
          check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
          held[mon_e.port] = mon_e.rdata;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!rsp_vec[p]) check("rsp_rdata_hold", 64'(rsp_rd[p]), 64'(held[p]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i + 1);
    held[0] = '0;
    held[1] = '0;
    drive(0, 1'b0, mk(1'b0, 0, 32'd0));
    drive(1, 1'b0, mk(1'b0, 0, 32'd0));

    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    check("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    check("rst_rsp0_rdata", 64'(bus.rsp0_rdata), 64'd0);
    check("rst_rsp1_rdata", 64'(bus.rsp1_rdata), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_strobes", 64'({bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Port 0 load at address 3
    pq[0].push_back(mk(1'b0, 3, 32'h0));
    drain();

    // Port 1 store then load at address 5
    pq[1].push_back(mk(1'b1, 5, 32'hDEADBEEF));
    pq[1].push_back(mk(1'b0, 5, 32'h0));
    drain();

    // Both ports contending: grants alternate
    pq[0].push_back(mk(1'b0, 1, 32'h0));
    pq[0].push_back(mk(1'b1, 7, 32'h1234_5678));
    pq[1].push_back(mk(1'b0, 2, 32'h0));
    pq[1].push_back(mk(1'b0, 7, 32'h0));
    drain();

    // Port 1 raises valid while port 0 is in ACCESS
    pq[0].push_back(mk(1'b0, 4, 32'h0));
    step();
    pq[1].push_back(mk(1'b0, 6, 32'h0));
    drain();

    // Reset during ACCESS
    pq[0].push_back(mk(1'b0, 9, 32'h0));
    n = 0;
    while (m_wait != 2 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("reset_test_accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    drive(0, 1'b0, mk(1'b0, 0, 32'd0));
    drive(1, 1'b0, mk(1'b0, 0, 32'd0));
    #3 rst = 1'b1;
    #1;
    check("async_rst_load_en", 64'(bus.mem_load_en), 64'd0);
    check("async_rst_store_en", 64'(bus.mem_store_en), 64'd0);
    check("async_rst_ldr_str_en", 64'(bus.mem_ldr_str_en), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    acc_q.delete();
    rsp_q.delete();
    m_wait = 0;
    last_grant = 1;
    held[0] = '0;
    held[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    pq[1].push_back(mk(1'b0, 9, 32'h0));
    drain();

    // Address boundaries
    pq[0].push_back(mk(1'b0, 15, 32'h0));
    drain();
    pq[1].push_back(mk(1'b0, 0, 32'h0));
    drain();

    // Randomized traffic
    dense = 1'b0;
    repeat (200) begin
      if ($urandom_range(0, 1) == 1) pq[$urandom_range(0, 1)].push_back(rand_txn());
      step();
    end
    drain();

    check("scoreboard_empty", 64'(acc_q.size() + rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port 16 x 32-bit data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/DMA loader.
- Round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse.
- Drives the memory's addr, write_data, ldr_str_en, load_en and store_en, and samples its read_data.
- Guarantees at most one memory access per cycle, and a strobe window exactly one cycle wide.

Parameters:
- ADDR_W, 4, memory word-address width (16 entries).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  port 0 request pending.
- req0_write  in  1  1 = store, 0 = load.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_wdata  in  DATA_W  port 0 store data.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  one-cycle completion pulse for port 0.
- rsp0_rdata  out  DATA_W  port 0 load result.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_ldr_str_en  out  1  memory access enable.
- mem_load_en  out  1  memory load strobe.
- mem_store_en  out  1  memory store strobe.
- mem_rdata  in  DATA_W  from memory read_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is asynchronous and active-high.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - reqN_ready = 1 combinationally for the granted port only, and only when that port's valid = 1.
  - On the accept edge, latch port id, write, addr and wdata; update the round-robin pointer; go to ACCESS.
  - With no valid request, stay in IDLE.
- ACCESS:
  - Drive mem_addr/mem_wdata from the latched fields; mem_ldr_str_en = 1.
  - Load: mem_load_en = 1, mem_store_en = 0. Store: the reverse.
  - At the end of the cycle, capture mem_rdata into the response register for loads; for stores, load 0 into it. Go to RESP.
- RESP:
  - rspN_valid = 1 for the latched port only; rspN_rdata = the captured value. Go to IDLE.
  - rspN_rdata holds its value until the next response to that port.
- Latency: accept at cycle T, memory strobe at T+1, rsp_valid at T+2. Next accept is possible at T+3.
- Throughput: one transaction per 3 cycles.
- Stores also produce an rsp_valid pulse, serving as the acknowledge.
- Arbitration:
  - Only one request is pending: grant it.
  - Both pending: grant the port not granted last.
  - The pointer resets so that port 0 wins the first contention.
- Requester rules:
  - A requester holds valid and its fields stable until ready. Changing fields while ready = 0 is permitted and has no effect.
  - ready is 0 in ACCESS and RESP. A request raised mid-transaction waits for IDLE.
- Memory idle level: all mem_* strobes are 0 outside ACCESS. mem_addr and mem_wdata hold their last values.
- Reset values: state IDLE; all ready, rsp_valid and mem strobes 0; rsp rdata 0; mem_addr 0; mem_wdata 0; busy 0.
- Reset mid-operation: the in-flight transaction is dropped. No rsp_valid is emitted, and the strobes deassert immediately (asynchronously).
- Address boundaries: addresses 0..15 are all valid; there is no wrap logic. The address is passed through unmodified.

Decomposition:
- Package mem_arb_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - the state enum (IDLE, ACCESS, RESP);
  - a mem_req struct {write, addr, wdata}.
- Sub-module rr_arbiter2:
  - 2-input round-robin grant with a pointer register, clk/rst, and an advance input.
  - Instantiated once.

Test Plan:
1. After reset, port 0 reads addr 3 (memory at init values) -> req0_ready at T; mem_load_en = 1 with mem_addr = 3 at T+1; rsp0_valid at T+2 with rsp0_rdata = 4.
2. Port 1 stores 0xDEADBEEF to addr 5, then reads addr 5 -> mem_store_en high exactly one cycle; store rsp1_rdata = 0; read rsp1_rdata = 0xDEADBEEF.
3. Both ports hold valid continuously for 4 transactions -> grants alternate 0,1,0,1 at 3-cycle spacing; responses go only to the matching port.
4. req1_valid rises during port 0's ACCESS -> req1_ready stays 0 through RESP; req1 is granted in the next IDLE cycle.
5. Assert rst during ACCESS -> mem strobes, busy and rsp_valid go to 0 without a clock edge; no response after reset release; the next request is granted normally.
6. Port 0 reads addr 15, then port 1 reads addr 0 -> rsp0_rdata = 16, rsp1_rdata = 1.
